// File: rtl/proc_pkg.sv
// Shared definitions for the WISC-style processor: fetch FSM state
// encoding and architectural reset constants.
package proc_pkg;

  // Fetch-stage state; encoding is shared with debug tooling.
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

  localparam logic [15:0] RESET_PC_DEF  = 16'h0000;
  localparam logic [15:0] NOP_INSTR_DEF = 16'h0800;

endpackage

// File: rtl/pc_incr.sv
// 16-bit +2 incrementer for the PC. Also used by execute as the branch base.
// The result wraps modulo 2^16 (16'hFFFE + 2 = 16'h0000).
module pc_incr (
  input  logic [15:0] pc_i,
  output logic [15:0] inc_pc_o
);

  // The carry out of bit 15 is dropped so the PC wraps silently.
  assign inc_pc_o = pc_i + 16'd2;

endmodule

// File: rtl/proc_fetch.sv
// Fetch stage: owns the PC, runs the multicycle instruction-memory
// handshake and holds the fetched instruction until decode advances.
// Optional build macro PC_ALIGN_CHECK_EN: an odd redirect target raises a
// sticky err and halts instead of being silently aligned.
module proc_fetch
  import proc_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        advance,
  input  logic        redirect,
  input  logic [15:0] targetPC,
  input  logic        isHalt,
  output logic        imemRd,
  output logic [15:0] imemAddr,
  input  logic        imemStall,
  input  logic        imemDone,
  input  logic [15:0] imemData,
  output logic [15:0] instr,
  output logic        instrValid,
  output logic [15:0] pc,
  output logic [15:0] incPC,
  output logic        halted,
  output logic        err
);

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [15:0]  instr_q, instr_d;
  logic         err_q, err_d;
  logic [15:0]  inc_pc;
  logic [15:0]  tgt_load;
  logic         tgt_misaligned;

  pc_incr u_pc_incr (
    .pc_i     (pc_q),
    .inc_pc_o (inc_pc)
  );

  // Redirect target as it is loaded into the PC, and whether it faults.
`ifdef PC_ALIGN_CHECK_EN
  assign tgt_load       = targetPC;
  assign tgt_misaligned = targetPC[0];
`else
  assign tgt_load       = targetPC & 16'hFFFE;
  assign tgt_misaligned = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (rst) state_q <= ST_FETCH;
    else     state_q <= state_d;
  end

  // Datapath registers: PC, held instruction, sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      err_q   <= err_d;
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    err_d   = err_q;
    unique case (state_q)
      ST_FETCH: begin
        if (!imemStall) begin
          if (imemDone) begin
            instr_d = imemData;
            state_d = ST_HOLD;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (imemDone) begin
          instr_d = imemData;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (advance) begin
          if (isHalt) begin
            state_d = ST_HALT;
          end else if (redirect) begin
            pc_d = tgt_load;
            if (tgt_misaligned) begin
              err_d   = 1'b1;
              state_d = ST_HALT;
            end else begin
              state_d = ST_FETCH;
            end
          end else begin
            pc_d    = inc_pc;
            state_d = ST_FETCH;
          end
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  // Output decode; the request is suppressed during the reset cycle.
  always_comb begin
    imemRd     = (state_q == ST_FETCH) && !rst;
    instrValid = (state_q == ST_HOLD);
    halted     = (state_q == ST_HALT);
  end

  assign imemAddr = pc_q;
  assign pc       = pc_q;
  assign incPC    = inc_pc;
  assign instr    = instr_q;
  assign err      = err_q;

endmodule

// File: tb/tb_proc_fetch.sv
// Self-checking bench for proc_fetch: directed vectors with literal
// expectations plus a transaction-level model compared every cycle.
module tb_proc_fetch;

  logic        clk = 1'b0;
  logic        rst, advance, redirect, isHalt;
  logic [15:0] targetPC;
  logic        imemStall, imemDone;
  logic [15:0] imemData;
  logic        imemRd, instrValid, halted, err;
  logic [15:0] imemAddr, instr, pc, incPC;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  proc_fetch dut (
    .clk(clk), .rst(rst), .advance(advance), .redirect(redirect),
    .targetPC(targetPC), .isHalt(isHalt), .imemRd(imemRd),
    .imemAddr(imemAddr), .imemStall(imemStall), .imemDone(imemDone),
    .imemData(imemData), .instr(instr), .instrValid(instrValid),
    .pc(pc), .incPC(incPC), .halted(halted), .err(err)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: the processor is either requesting, awaiting data, holding an
  // instruction for decode, or stopped; expressed as plain flags.
  bit       armed = 0;
  bit       m_req, m_await, m_have, m_stop, m_err;
  int       m_pc;
  bit [15:0] m_instr;

  always @(posedge clk) begin
    if (rst) begin
      armed = 1; m_pc = 0; m_instr = 16'h0800;
      m_req = 1; m_await = 0; m_have = 0; m_stop = 0; m_err = 0;
    end else if (armed) begin
      if (m_req) begin
        if (!imemStall) begin
          m_req = 0;
          if (imemDone) begin m_instr = imemData; m_have = 1; end
          else m_await = 1;
        end
      end else if (m_await) begin
        if (imemDone) begin m_instr = imemData; m_have = 1; m_await = 0; end
      end else if (m_have && advance) begin
        m_have = 0;
        if (isHalt) m_stop = 1;
        else if (redirect) begin
`ifdef PC_ALIGN_CHECK_EN
          m_pc = targetPC;
          if (targetPC[0]) begin m_err = 1; m_stop = 1; end
          else m_req = 1;
`else
          m_pc = targetPC - (targetPC % 2);
          m_req = 1;
`endif
        end else begin
          m_pc = (m_pc + 2) % 65536;
          m_req = 1;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (armed) begin
      check("m_imemRd", imemRd, (m_req && !rst) ? 16'd1 : 16'd0);
      check("m_imemAddr", imemAddr, 16'(m_pc));
      check("m_pc", pc, 16'(m_pc));
      check("m_incPC", incPC, 16'((m_pc + 2) % 65536));
      check("m_instr", instr, m_instr);
      check("m_instrValid", instrValid, m_have ? 16'd1 : 16'd0);
      check("m_halted", halted, m_stop ? 16'd1 : 16'd0);
      check("m_err", err, m_err ? 16'd1 : 16'd0);
    end
  end

  // Step to just after the next falling edge; outputs are settled there.
  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic hit(input logic [15:0] d);
    imemDone = 1; imemData = d; tick(); imemDone = 0;
  endtask

  task automatic adv(input logic rd, input logic [15:0] tgt, input logic hlt);
    advance = 1; redirect = rd; targetPC = tgt; isHalt = hlt;
    tick();
    advance = 0; redirect = 0; isHalt = 0;
  endtask

  initial begin
    rst = 1; advance = 0; redirect = 0; isHalt = 0; targetPC = 0;
    imemStall = 0; imemDone = 0; imemData = 0;
    tick();
    check("rst_imemRd", imemRd, 1'b0);
    check("rst_pc", pc, 16'h0000);
    check("rst_instr", instr, 16'h0800);
    check("rst_valid", instrValid, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_err", err, 1'b0);

    // Zero-wait hit.
    rst = 0; imemDone = 1; imemData = 16'h4123; #1;
    check("zw_rd", imemRd, 1'b1);
    check("zw_addr", imemAddr, 16'h0000);
    tick(); imemDone = 0;
    check("zw_valid", instrValid, 1'b1);
    check("zw_instr", instr, 16'h4123);
    adv(0, 16'h0000, 0);
    check("zw_next_addr", imemAddr, 16'h0002);
    check("zw_incpc", incPC, 16'h0004);

    // Miss: done arrives three cycles after the request; advance ignored.
    tick(); advance = 1;
    check("miss_rd_drop", imemRd, 1'b0);
    tick();
    tick(); advance = 0;
    check("miss_pc_kept", pc, 16'h0002);
    check("miss_not_valid", instrValid, 1'b0);
    hit(16'h1234);
    check("miss_valid", instrValid, 1'b1);
    check("miss_instr", instr, 16'h1234);

    // Stall for two cycles.
    adv(0, 16'h0000, 0);
    imemStall = 1;
    check("stall_rd1", imemRd, 1'b1);
    tick();
    check("stall_rd2", imemRd, 1'b1);
    tick(); imemStall = 0;
    check("stall_rd3", imemRd, 1'b1);
    check("stall_addr", imemAddr, 16'h0004);
    tick();
    check("stall_wait", imemRd, 1'b0);
    hit(16'hABCD);
    check("stall_instr", instr, 16'hABCD);

    // Redirects and wrap.
    adv(1, 16'h0010, 0);
    hit(16'h2000);
    adv(1, 16'h0100, 0);
    check("redir_addr", imemAddr, 16'h0100);
    hit(16'h2001);
    adv(1, 16'hFFFE, 0);
    check("ffe_incpc", incPC, 16'h0000);
    hit(16'h2002);
    adv(0, 16'h0000, 0);
    check("wrap_addr", imemAddr, 16'h0000);
    hit(16'h2003);
    adv(1, 16'h0020, 0);
    hit(16'h2004);

    // Halt wins over redirect; stray inputs afterwards are ignored.
    adv(1, 16'h0300, 1);
    check("halt_halted", halted, 1'b1);
    check("halt_pc", pc, 16'h0020);
    check("halt_rd", imemRd, 1'b0);
    imemDone = 1; advance = 1; redirect = 1; targetPC = 16'h0400;
    tick(); tick();
    imemDone = 0; advance = 0; redirect = 0;
    check("halt_stuck", halted, 1'b1);
    check("halt_rd2", imemRd, 1'b0);
    rst = 1; tick();
    rst = 0; #1;
    check("rst2_pc", pc, 16'h0000);
    check("rst2_rd", imemRd, 1'b1);
    check("rst2_halted", halted, 1'b0);

    // Odd redirect target.
    hit(16'h3000);
    adv(1, 16'h0103, 0);
`ifdef PC_ALIGN_CHECK_EN
    check("align_err", err, 1'b1);
    check("align_halted", halted, 1'b1);
    check("align_pc", pc, 16'h0103);
    check("align_rd", imemRd, 1'b0);
`else
    check("align_addr", imemAddr, 16'h0102);
    check("align_err", err, 1'b0);
    check("align_rd", imemRd, 1'b1);
`endif
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
